bitonic_s3_pipe: RTL and testbench



---
 rtl/bitonic_s3_pipe.sv | 127 ++++++++++++
 tb/tb_bitonic_s3_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_s3_pipe.sv
// Final merge stage of an 8-input bitonic sorter.
// Takes a bitonic vector (elements 1-4 descending, 5-8 ascending), applies the
// three remaining compare-exchange layers across a 3-deep registered pipeline
// with valid/ready flow control, and emits the vector sorted ascending.
// out_cnt counts delivered vectors modulo 256.
module bitonic_s3_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] number_in1,
  input  logic [7:0] number_in2,
  input  logic [7:0] number_in3,
  input  logic [7:0] number_in4,
  input  logic [7:0] number_in5,
  input  logic [7:0] number_in6,
  input  logic [7:0] number_in7,
  input  logic [7:0] number_in8,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] number_out1,
  output logic [7:0] number_out2,
  output logic [7:0] number_out3,
  output logic [7:0] number_out4,
  output logic [7:0] number_out5,
  output logic [7:0] number_out6,
  output logic [7:0] number_out7,
  output logic [7:0] number_out8,
  output logic [7:0] out_cnt
);

  localparam int DATA_W = 8;

  // Element [0] is position 1 (smallest after sorting), element [7] is position 8.
  typedef logic [7:0][DATA_W-1:0] vec_t;

  // One compare-exchange layer: every index i whose bit(s) in d are clear is
  // paired with i|d; the lower value lands on i. Equal values stay put.
  // The pairs within a layer are disjoint, so all reads come from v.
  function automatic vec_t cmpx_layer(input vec_t v, input logic [2:0] d);
    vec_t       r;
    logic [2:0] i;
    r = v;
    for (int k = 0; k < 8; k++) begin
      i = 3'(k);
      if (((i & d) == 3'd0) && (v[i] > v[i | d])) begin
        r[i]     = v[i | d];
        r[i | d] = v[i];
      end
    end
    return r;
  endfunction

  vec_t din;
  vec_t data_p0;
  vec_t data_p1;
  vec_t data_p2;
  logic vld_p0;
  logic vld_p1;
  logic vld_p2;
  logic rdy_p0;
  logic rdy_p1;
  logic rdy_p2;

  assign din = {number_in8, number_in7, number_in6, number_in5,
                number_in4, number_in3, number_in2, number_in1};

  // A stage may advance when it is empty or its successor is advancing;
  // this lets bubbles collapse and keeps full throughput under out_ready=1.
  assign rdy_p2   = !vld_p2 || out_ready;
  assign rdy_p1   = !vld_p1 || rdy_p2;
  assign rdy_p0   = !vld_p0 || rdy_p1;
  assign in_ready = rst_n && rdy_p0;

  // Stage A: layer (1,5)(2,6)(3,7)(4,8) applied to the incoming vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (rdy_p0) begin
      vld_p0  <= in_valid;
      data_p0 <= cmpx_layer(din, 3'd4);
    end
  end

  // Stage B: layer (1,3)(2,4)(5,7)(6,8) applied to register A.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (rdy_p1) begin
      vld_p1  <= vld_p0;
      data_p1 <= cmpx_layer(data_p0, 3'd2);
    end
  end

  // Stage C: layer (1,2)(3,4)(5,6)(7,8) applied to register B; drives the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (rdy_p2) begin
      vld_p2  <= vld_p1;
      data_p2 <= cmpx_layer(data_p1, 3'd1);
    end
  end

  // Count completed output transfers, wrapping at 256.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt <= 8'd0;
    end else if (vld_p2 && out_ready) begin
      out_cnt <= out_cnt + 8'd1;
    end
  end

  assign out_valid   = vld_p2;
  assign number_out1 = data_p2[0];
  assign number_out2 = data_p2[1];
  assign number_out3 = data_p2[2];
  assign number_out4 = data_p2[3];
  assign number_out5 = data_p2[4];
  assign number_out6 = data_p2[5];
  assign number_out7 = data_p2[6];
  assign number_out8 = data_p2[7];

endmodule

// File: tb/tb_bitonic_s3_pipe.sv
// Scoreboard bench for bitonic_s3_pipe: the driver pushes the expected sorted
// vector when a transfer is accepted, a negedge monitor pops and compares on
// every output transfer.
module tb_bitonic_s3_pipe;

  typedef logic [7:0][7:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  vec_t       in_vec = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_cnt;
  logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8;
  vec_t       out_vec;

  int         checks = 0;
  int         failures = 0;
  vec_t       exp_q[$];
  vec_t       mon_e;
  logic [7:0] exp_cnt = 8'd0;
  logic       prev_stall = 1'b0;
  vec_t       prev_vec = '0;
  int         cyc = 0;
  bit         in_stream = 1'b0;
  int         s_first = -1;
  int         s_last = -1;
  bit         saw_low = 1'b0;

  assign out_vec = {o8, o7, o6, o5, o4, o3, o2, o1};

  bitonic_s3_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .number_in1  (in_vec[0]),
    .number_in2  (in_vec[1]),
    .number_in3  (in_vec[2]),
    .number_in4  (in_vec[3]),
    .number_in5  (in_vec[4]),
    .number_in6  (in_vec[5]),
    .number_in7  (in_vec[6]),
    .number_in8  (in_vec[7]),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .number_out1 (o1),
    .number_out2 (o2),
    .number_out3 (o3),
    .number_out4 (o4),
    .number_out5 (o5),
    .number_out6 (o6),
    .number_out7 (o7),
    .number_out8 (o8),
    .out_cnt     (out_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input int a1, input int a2, input int a3, input int a4,
                              input int a5, input int a6, input int a7, input int a8);
    vec_t r;
    r[0] = 8'(a1); r[1] = 8'(a2); r[2] = 8'(a3); r[3] = 8'(a4);
    r[4] = 8'(a5); r[5] = 8'(a6); r[6] = 8'(a7); r[7] = 8'(a8);
    return r;
  endfunction

  // Reference model: plain insertion sort, ascending.
  function automatic vec_t sort_vec(input vec_t v);
    vec_t       r;
    logic [7:0] t;
    r = v;
    for (int i = 1; i < 8; i++)
      for (int j = i; j > 0; j--)
        if (r[j-1] > r[j]) begin
          t = r[j]; r[j] = r[j-1]; r[j-1] = t;
        end
    return r;
  endfunction

  // Random bitonic vector: interleave a sorted set into a descending then ascending half.
  task automatic make_rand(output vec_t vin, output vec_t vexp);
    vec_t r;
    vec_t a;
    for (int k = 0; k < 8; k++) r[k] = 8'($urandom_range(0, 255));
    a    = sort_vec(r);
    vin  = mk(a[7], a[5], a[3], a[1], a[0], a[2], a[4], a[6]);
    vexp = a;
  endtask

  // Must be called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input vec_t e);
    bit done;
    done = 1'b0;
    in_vec = v;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic latency(string name);
    int lat;
    lat = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check(name, 64'(lat), 64'd3);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_cnt = 8'd0;
    prev_stall = 1'b0;
    rst_n = 1'b1;
  endtask

  // Output monitor: scoreboard compare, counter check, hold-while-stalled check.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_data", out_vec, prev_vec);
        check("hold_valid", 64'(out_valid), 64'd1);
      end
      prev_stall <= out_valid && !out_ready;
      prev_vec   <= out_vec;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sorted_out", out_vec, mon_e);
        end
        check("out_cnt_running", 64'(out_cnt), 64'(exp_cnt));
        exp_cnt <= exp_cnt + 8'd1;
        if (in_stream) begin
          if (s_first < 0) s_first <= cyc;
          s_last <= cyc;
        end
      end
    end
  end

  // in_ready must fall exactly when three vectors are buffered and out_ready is low.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        check("in_ready_in_reset", 64'(in_ready), 64'd0);
      end else begin
        check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 3 && !out_ready)));
        if (!in_ready) saw_low = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vi;
    vec_t ve;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_cnt", 64'(out_cnt), 64'd0);
    check("rst_out_data", out_vec, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Basic sort with latency
    send(mk(200, 150, 90, 10, 5, 60, 120, 255), mk(5, 10, 60, 90, 120, 150, 200, 255));
    latency("latency_basic");
    drain();
    check("cnt_basic", 64'(out_cnt), 64'd1);

    // Ties and extremes
    send(mk(255, 255, 255, 255, 255, 255, 255, 255), mk(255, 255, 255, 255, 255, 255, 255, 255));
    send(mk(0, 0, 0, 0, 0, 0, 0, 255), mk(0, 0, 0, 0, 0, 0, 0, 255));
    drain();

    // Backpressure: out_ready low for cycles 2..7 while 5 vectors stream in
    do_reset();
    saw_low = 1'b0;
    fork
      begin
        send(mk(9, 7, 5, 3, 2, 4, 6, 8), mk(2, 3, 4, 5, 6, 7, 8, 9));
        send(mk(100, 50, 40, 1, 0, 30, 70, 99), mk(0, 1, 30, 40, 50, 70, 99, 100));
        send(mk(255, 254, 253, 252, 0, 1, 2, 3), mk(0, 1, 2, 3, 252, 253, 254, 255));
        send(mk(80, 80, 20, 20, 10, 10, 90, 90), mk(10, 10, 20, 20, 80, 80, 90, 90));
        send(mk(33, 22, 11, 0, 44, 55, 66, 77), mk(0, 11, 22, 33, 44, 55, 66, 77));
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          out_ready = !(c >= 2 && c <= 7);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_fell", 64'(saw_low), 64'd1);
    check("bp_out_cnt", 64'(out_cnt), 64'd5);

    // Full-rate streaming of random bitonic vectors
    s_first = -1; s_last = -1;
    in_stream = 1'b1;
    for (int n = 0; n < 20; n++) begin
      make_rand(vi, ve);
      send(vi, ve);
    end
    drain();
    in_stream = 1'b0;
    check("stream_consecutive", 64'(s_last - s_first), 64'd19);

    // Reset mid-operation with two vectors in flight
    send(mk(9, 7, 5, 3, 2, 4, 6, 8), mk(2, 3, 4, 5, 6, 7, 8, 9));
    send(mk(100, 50, 40, 1, 0, 30, 70, 99), mk(0, 1, 30, 40, 50, 70, 99, 100));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_cnt", 64'(out_cnt), 64'd0);
    check("midrst_out_data", out_vec, 64'd0);
    exp_q.delete();
    exp_cnt = 8'd0;
    prev_stall = 1'b0;
    rst_n = 1'b1;
    send(mk(60, 50, 40, 30, 35, 45, 55, 65), mk(30, 35, 40, 45, 50, 55, 60, 65));
    latency("latency_after_rst");
    drain();
    check("midrst_cnt_after", 64'(out_cnt), 64'd1);

    // Counter wrap over 257 transfers
    do_reset();
    for (int n = 0; n < 257; n++) begin
      make_rand(vi, ve);
      send(vi, ve);
    end
    drain();
    check("wrap_cnt_final", 64'(out_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
